// File: rtl/fpu_ieee_operand_stage_if.sv
// Handshake bundle between the IEEE operand source, the operand stage and the FPU adder.
// Both the input pair and the converted native pair travel with valid/ready.
interface fpu_ieee_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ieee_a;
    logic [31:0] ieee_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [5:0]  flags;

    modport master (
        output in_valid, ieee_a, ieee_b, out_ready,
        input  in_ready, out_valid, op_a, op_b, flags
    );

    modport slave (
        input  in_valid, ieee_a, ieee_b, out_ready,
        output in_ready, out_valid, op_a, op_b, flags
    );
endinterface

// File: rtl/fpu_ieee_operand_stage.sv
// Two-stage pipeline converting IEEE-754 single operand pairs into the FPU native word
// {sign, exp (bias BIAS), mantissa with hidden 1}, with per-pair flags, sticky flags and a delivery counter.
module fpu_ieee_operand_stage #(
    parameter int EXP_W  = 6,
    parameter int MANT_W = 25,
    parameter int BIAS   = 31,
    parameter int CNT_W  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    fpu_ieee_operand_stage_if.slave    bus,
    input  logic                       clear,
    output logic [2:0]                 sticky,
    output logic [CNT_W-1:0]           conv_count
);

    localparam int EXP_MAX = (1 << EXP_W) - 1;

    typedef struct packed {
        logic [31:0] word;
        logic        nan;
        logic        ovf;
        logic        unf;
    } conv_t;

    // Native exponent 0 is reserved for zero, so anything mapping below 1 flushes to signed zero.
    function automatic conv_t convert(input logic [31:0] x);
        conv_t       r;
        logic        sign;
        logic [7:0]  e8;
        logic [22:0] m23;
        int          native_exp;
        sign       = x[31];
        e8         = x[30:23];
        m23        = x[22:0];
        native_exp = int'(e8) - 127 + BIAS;
        r.word     = {sign, 31'b0};
        r.nan      = 1'b0;
        r.ovf      = 1'b0;
        r.unf      = 1'b0;
        if (e8 == 8'hFF) begin
            r.word = {sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
            r.nan  = (m23 != '0);
            r.ovf  = (m23 == '0);
        end else if (e8 == 8'h00) begin
            r.unf  = (m23 != '0);
        end else if (native_exp > EXP_MAX) begin
            r.word = {sign, {EXP_W{1'b1}}, {MANT_W{1'b1}}};
            r.ovf  = 1'b1;
        end else if (native_exp < 1) begin
            r.unf  = 1'b1;
        end else begin
            r.word = {sign, native_exp[EXP_W-1:0], m23, {(MANT_W-23){1'b0}}};
        end
        return r;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [31:0]          s1_a_q, s1_a_d;
    logic [31:0]          s1_b_q, s1_b_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          op_a_q, op_a_d;
    logic [31:0]          op_b_q, op_b_d;
    logic [5:0]           flags_q, flags_d;
    logic [2:0]           sticky_q, sticky_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic  adv1, adv2, deliver;
    conv_t conv_a, conv_b;

    assign adv2    = !s2_valid_q || bus.out_ready;
    assign adv1    = !s1_valid_q || adv2;
    assign deliver = s2_valid_q && bus.out_ready;
    assign conv_a  = convert(s1_a_q);
    assign conv_b  = convert(s1_b_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d = bus.ieee_a;
                s1_b_d = bus.ieee_b;
            end
        end
    end

    // Output registers only load on a real advance so a stalled word stays stable until consumed.
    always_comb begin
        s2_valid_d = s2_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        flags_d    = flags_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                op_a_d  = conv_a.word;
                op_b_d  = conv_b.word;
                flags_d = {conv_a.nan, conv_a.ovf, conv_a.unf,
                           conv_b.nan, conv_b.ovf, conv_b.unf};
            end
        end
    end

    // A same-cycle clear wins and swallows the delivery it coincides with.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clear) begin
            sticky_d = '0;
            count_d  = '0;
        end else if (deliver) begin
            sticky_d = sticky_q | {flags_q[5] | flags_q[2],
                                   flags_q[4] | flags_q[1],
                                   flags_q[3] | flags_q[0]};
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            flags_q    <= '0;
            sticky_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            flags_q    <= flags_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.flags     = flags_q;
    assign sticky        = sticky_q;
    assign conv_count    = count_q;

endmodule

// File: tb/tb_fpu_ieee_operand_stage.sv
// Self-checking bench for fpu_ieee_operand_stage: directed vectors, randomized traffic against
// an IEEE-rule reference model with a scoreboard, stalls, mid-flight reset, counter wrap and clear.
module tb_fpu_ieee_operand_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [2:0]  sticky;
    logic [15:0] conv_count;

    fpu_ieee_operand_stage_if bus();

    fpu_ieee_operand_stage dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .clear      (clear),
        .sticky     (sticky),
        .conv_count (conv_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
    } pair_t;

    pair_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  m_sticky;
    logic [15:0] m_count;

    // Reference conversion from the IEEE value rules: returns {native word, nan, ovf, unf}.
    function automatic logic [34:0] ref_conv(input logic [31:0] x);
        logic        s;
        int          e8;
        int          e_unb;
        logic [22:0] frac;
        logic [5:0]  ne;
        s     = x[31];
        e8    = int'(x[30:23]);
        frac  = x[22:0];
        e_unb = e8 - 127;
        if (e8 == 255)   return {s, 31'h7FFFFFFF, frac != 0, frac == 0, 1'b0};
        if (e8 == 0)     return {s, 31'h00000000, 2'b00, frac != 0};
        if (e_unb > 32)  return {s, 31'h7FFFFFFF, 3'b010};
        if (e_unb < -30) return {s, 31'h00000000, 3'b001};
        ne = 6'(e_unb + 31);
        return {s, ne, frac, 2'b00, 3'b000};
    endfunction

    function automatic pair_t make_pair(input logic [31:0] a, input logic [31:0] b);
        logic [34:0] ra;
        logic [34:0] rb;
        ra = ref_conv(a);
        rb = ref_conv(b);
        return {ra[34:3], rb[34:3], ra[2:0], rb[2:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e8;
        logic [22:0] m;
        logic        s;
        int          sel;
        sel = $urandom_range(0, 7);
        s   = 1'($urandom_range(0, 1));
        m   = 23'($urandom);
        if ($urandom_range(0, 3) == 0) m = '0;
        case (sel)
            0:       e8 = 8'hFF;
            1:       e8 = 8'h00;
            2:       e8 = 8'($urandom_range(158, 161));
            3:       e8 = 8'($urandom_range(95, 98));
            default: e8 = 8'($urandom_range(0, 255));
        endcase
        return {s, e8, m};
    endfunction

    // One clock of traffic: drive, sample just after the drive, keep the model in step, advance to the next negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic clr,
                        output logic irdy, output logic exp_irdy, output logic ov,
                        output logic dlv, output pair_t got,
                        output logic have_exp, output pair_t expd);
        bus.in_valid  = v;
        bus.ieee_a    = a;
        bus.ieee_b    = b;
        bus.out_ready = ordy;
        clear         = clr;
        #1;
        exp_irdy = !(sb.size() == 2 && !ordy);
        irdy     = bus.in_ready;
        ov       = bus.out_valid;
        dlv      = ov && ordy;
        got      = {bus.op_a, bus.op_b, bus.flags};
        have_exp = 1'b0;
        expd     = '0;
        if (dlv && sb.size() > 0) begin
            expd     = sb.pop_front();
            have_exp = 1'b1;
        end
        if (v && irdy) sb.push_back(make_pair(a, b));
        if (clr) begin
            m_sticky = '0;
            m_count  = '0;
        end else if (dlv) begin
            m_sticky = m_sticky | {expd.f[5] | expd.f[2], expd.f[4] | expd.f[1], expd.f[3] | expd.f[0]};
            m_count  = m_count + 16'd1;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ieee_a    = '0;
        bus.ieee_b    = '0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.op_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_op_a: got %h expected 00000000", bus.op_a); end
        if (bus.op_b !== 32'h0) begin errors++; $display("[TB] FAIL reset_op_b: got %h expected 00000000", bus.op_b); end
        if (bus.flags !== 6'h0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", bus.flags); end
        if (sticky !== 3'b000) begin errors++; $display("[TB] FAIL reset_sticky: got %b expected 000", sticky); end
        if (conv_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0000", conv_count); end
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        m_sticky = '0;
        m_count  = '0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [31:0] va[6]  = '{32'h3F800000, 32'h4F800000, 32'h7FC00000, 32'h3F800000, 32'h30800000, 32'h00000001};
        logic [31:0] vb[6]  = '{32'hC0200000, 32'h50000000, 32'h30000000, 32'h80000000, 32'hFF800000, 32'h7F800001};
        logic [31:0] ea[6]  = '{32'h3E000000, 32'h7E000000, 32'h7FFFFFFF, 32'h3E000000, 32'h02000000, 32'h00000000};
        logic [31:0] eb[6]  = '{32'hC0800000, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [5:0]  ef[6]  = '{6'b000000, 6'b000010, 6'b100001, 6'b000000, 6'b000010, 6'b001100};
        logic [2:0]  es[6]  = '{3'b000, 3'b010, 3'b111, 3'b111, 3'b111, 3'b111};
        logic irdy, eirdy, ov, dlv, hv;
        pair_t got, expd;
        int lat;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, va[i], vb[i], 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            lat = 0;
            dlv = 1'b0;
            while (!dlv && lat < 6) begin
                lat++;
                step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            end
            checks += 6;
            if (lat !== 2) begin errors++; $display("[TB] FAIL dir%0d_latency: got %0d expected 2", i, lat); end
            if (got.a !== ea[i]) begin errors++; $display("[TB] FAIL dir%0d_op_a: got %h expected %h", i, got.a, ea[i]); end
            if (got.b !== eb[i]) begin errors++; $display("[TB] FAIL dir%0d_op_b: got %h expected %h", i, got.b, eb[i]); end
            if (got.f !== ef[i]) begin errors++; $display("[TB] FAIL dir%0d_flags: got %b expected %b", i, got.f, ef[i]); end
            if (sticky !== es[i]) begin errors++; $display("[TB] FAIL dir%0d_sticky: got %b expected %b", i, sticky, es[i]); end
            if (conv_count !== 16'(i + 1)) begin errors++; $display("[TB] FAIL dir%0d_count: got %0d expected %0d", i, conv_count, i + 1); end
        end
    endtask

    task automatic test_random();
        logic irdy, eirdy, ov, dlv, hv, ordy, prev_stall;
        pair_t got, expd, prev_got;
        prev_stall = 1'b0;
        prev_got   = '0;
        for (int c = 0; c < 400; c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, rand_fp(), rand_fp(), ordy, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            checks += 3;
            if (irdy !== eirdy) begin errors++; $display("[TB] FAIL rnd_in_ready c%0d: got %b expected %b", c, irdy, eirdy); end
            if (sticky !== m_sticky) begin errors++; $display("[TB] FAIL rnd_sticky c%0d: got %b expected %b", c, sticky, m_sticky); end
            if (conv_count !== m_count) begin errors++; $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", c, conv_count, m_count); end
            if (dlv) begin
                checks++;
                if (!hv || got !== expd) begin errors++; $display("[TB] FAIL rnd_data c%0d: got %h expected %h (expected-present=%b)", c, got, expd, hv); end
            end
            if (prev_stall && ov) begin
                checks++;
                if (got !== prev_got) begin errors++; $display("[TB] FAIL rnd_hold c%0d: got %h expected %h", c, got, prev_got); end
            end
            prev_stall = ov && !ordy;
            prev_got   = got;
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            if (dlv) begin
                checks++;
                if (!hv || got !== expd) begin errors++; $display("[TB] FAIL rnd_drain: got %h expected %h", got, expd); end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL rnd_drain_empty: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic irdy, eirdy, ov, dlv, hv, ordy;
        pair_t got, expd, held;
        logic [15:0] start_count;
        int sent, delivered, stalls, accepts_before_stall;
        logic stalled_once;
        start_count = m_count;
        sent = 0; delivered = 0; stalls = 0; accepts_before_stall = 0;
        stalled_once = 1'b0;
        held = '0;
        for (int c = 0; c < 30 && delivered < 8; c++) begin
            ordy = !(c >= 2 && c <= 5);
            step(sent < 8, 32'h3F800000 + 32'(sent << 20), 32'hC1000000 - 32'(sent << 21), ordy, 1'b0,
                 irdy, eirdy, ov, dlv, got, hv, expd);
            checks++;
            if (irdy !== eirdy) begin errors++; $display("[TB] FAIL b2b_in_ready c%0d: got %b expected %b", c, irdy, eirdy); end
            if (!irdy) begin
                stalls++;
                stalled_once = 1'b1;
            end
            if (sent < 8 && irdy) begin
                sent++;
                if (!stalled_once) accepts_before_stall++;
            end
            if (c == 2) held = got;
            if (c > 2 && c <= 5) begin
                checks++;
                if (got !== held) begin errors++; $display("[TB] FAIL b2b_hold c%0d: got %h expected %h", c, got, held); end
            end
            if (dlv) begin
                delivered++;
                checks++;
                if (!hv || got !== expd) begin errors++; $display("[TB] FAIL b2b_data c%0d: got %h expected %h", c, got, expd); end
            end
        end
        checks += 4;
        if (delivered !== 8) begin errors++; $display("[TB] FAIL b2b_delivered: got %0d expected 8", delivered); end
        if (stalls !== 4) begin errors++; $display("[TB] FAIL b2b_stall_cycles: got %0d expected 4", stalls); end
        if (accepts_before_stall !== 2) begin errors++; $display("[TB] FAIL b2b_accepts_before_stall: got %0d expected 2", accepts_before_stall); end
        if (conv_count !== start_count + 16'd8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", conv_count, start_count + 16'd8); end
    endtask

    task automatic test_reset_mid_flight();
        logic irdy, eirdy, ov, dlv, hv;
        pair_t got, expd;
        step(1'b1, 32'h40400000, 32'h7F800000, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        step(1'b1, 32'h40800000, 32'h00400000, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
        reset = 1'b1;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        if (sticky !== 3'b000) begin errors++; $display("[TB] FAIL mid_sticky: got %b expected 000", sticky); end
        if (conv_count !== 16'h0) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 0", conv_count); end
        if (bus.op_a !== 32'h0) begin errors++; $display("[TB] FAIL mid_op_a: got %h expected 00000000", bus.op_a); end
        sb.delete();
        m_sticky = '0;
        m_count  = '0;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            checks++;
            if (ov !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_valid c%0d: got %b expected 0", c, ov); end
        end
        checks++;
        if (conv_count !== 16'h0) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected 0", conv_count); end
    endtask

    task automatic test_wrap_and_clear();
        logic irdy, eirdy, ov, dlv, hv;
        pair_t got, expd;
        int guard;
        guard = 0;
        while (int'(m_count) + sb.size() < 65535 && guard < 70000) begin
            step(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
            guard++;
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        checks++;
        if (conv_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_top: got %h expected ffff", conv_count); end
        step(1'b1, 32'h7FC00000, 32'h00000000, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        for (int c = 0; c < 6 && sb.size() > 0; c++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        checks += 2;
        if (conv_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero: got %h expected 0000", conv_count); end
        if (sticky !== 3'b100) begin errors++; $display("[TB] FAIL wrap_sticky: got %b expected 100", sticky); end
        step(1'b1, 32'h7F800000, 32'h00000001, 1'b0, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        ov = 1'b0;
        for (int c = 0; c < 6 && !ov; c++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, irdy, eirdy, ov, dlv, got, hv, expd);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, irdy, eirdy, ov, dlv, got, hv, expd);
        clear = 1'b0;
        checks += 4;
        if (dlv !== 1'b1) begin errors++; $display("[TB] FAIL clear_delivery: got %b expected 1", dlv); end
        if (got !== {32'h7FFFFFFF, 32'h00000000, 6'b010001}) begin errors++; $display("[TB] FAIL clear_data: got %h expected %h", got, {32'h7FFFFFFF, 32'h00000000, 6'b010001}); end
        if (sticky !== 3'b000) begin errors++; $display("[TB] FAIL clear_sticky: got %b expected 000", sticky); end
        if (conv_count !== 16'h0000) begin errors++; $display("[TB] FAIL clear_count: got %h expected 0000", conv_count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_flight();
        test_wrap_and_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete in time");
    end

endmodule
